// File: rtl/barbecue_pkg.sv
// barbecue_pkg: shared widths, sprite geometry, FSM state type and colour defaults for the barbecue display blocks.
package barbecue_pkg;
  localparam int COORD_W = 8;
  localparam int COLOUR_W = 9;
  localparam int NUM_SLOTS = 6;
  localparam int SPRITE_W = 8;
  localparam int SPRITE_H = 5;
  localparam logic [COLOUR_W-1:0] DEFAULT_FAT = 9'h1b6;
  localparam logic [COLOUR_W-1:0] DEFAULT_MUSCLE = 9'h180;
  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
  function automatic logic is_border(input int col, input int row, input int w, input int h);
    return col == 0 || row == 0 || col == w - 1 || row == h - 1;
  endfunction
endpackage

// File: rtl/steak_draw_arbiter_rr_picker.sv
// rr_picker: combinational rotating-priority encoder; first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int N = 6,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[IDX_W'((int'(ptr) + k) % N)]) begin
        valid = 1'b1;
        index = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/steak_draw_arbiter.sv
// steak_draw_arbiter: round-robin redraw of dirty steak sprites through the single VGA write port.
// Define FULL_REFRESH_EN to force a redraw of every slot each REFRESH_PERIOD cycles.
module steak_draw_arbiter
  import barbecue_pkg::*;
#(
  parameter int NUM_SLOTS = barbecue_pkg::NUM_SLOTS,
  parameter int SPRITE_W = barbecue_pkg::SPRITE_W,
  parameter int SPRITE_H = barbecue_pkg::SPRITE_H,
  parameter int REFRESH_PERIOD = 1000000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_SLOTS-1:0]          req,
  input  logic [COORD_W*NUM_SLOTS-1:0]  base_x_flat,
  input  logic [COORD_W*NUM_SLOTS-1:0]  base_y_flat,
  input  logic [COLOUR_W*NUM_SLOTS-1:0] fat_flat,
  input  logic [COLOUR_W*NUM_SLOTS-1:0] muscle_flat,
  output logic [COORD_W-1:0]            x_out,
  output logic [COORD_W-1:0]            y_out,
  output logic [COLOUR_W-1:0]           colour_out,
  output logic                          plot,
  output logic [NUM_SLOTS-1:0]          ack,
  output logic                          busy
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);
  state_t state, nxt;
  logic [IDX_W-1:0] ptr, grant, pick_idx;
  logic pick_valid, last;
  logic [NUM_SLOTS-1:0] eff_req;
  logic [COORD_W-1:0] bx, by, src_bx, src_by;
  logic [COLOUR_W-1:0] fat, muscle, src_fat, src_muscle;
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row, row_n;
`ifdef FULL_REFRESH_EN
  localparam int RC_W = $clog2(REFRESH_PERIOD);
  logic [RC_W-1:0] rcnt;
  logic [NUM_SLOTS-1:0] pending;
  logic wrap;
  assign wrap = rcnt == RC_W'(REFRESH_PERIOD - 1);
  // a wrap coinciding with an ack re-arms that slot rather than clearing it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rcnt <= '0;
      pending <= '0;
    end else begin
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      pending <= wrap ? '1 : pending & ~ack;
    end
  end
  assign eff_req = req | pending;
`else
  assign eff_req = req;
`endif
  rr_picker #(.N(NUM_SLOTS), .IDX_W(IDX_W)) u_pick (
    .req(eff_req), .ptr(ptr), .valid(pick_valid), .index(pick_idx)
  );
  // in LOAD the sprite source is the live inputs; afterwards only the snapshot
  always_comb begin
    src_bx = state == LOAD ? base_x_flat[grant*COORD_W +: COORD_W] : bx;
    src_by = state == LOAD ? base_y_flat[grant*COORD_W +: COORD_W] : by;
    src_fat = state == LOAD ? fat_flat[grant*COLOUR_W +: COLOUR_W] : fat;
    src_muscle = state == LOAD ? muscle_flat[grant*COLOUR_W +: COLOUR_W] : muscle;
    last = col == COL_W'(SPRITE_W - 1) && row == ROW_W'(SPRITE_H - 1);
    col_n = state == DRAW ? (col == COL_W'(SPRITE_W - 1) ? '0 : col + 1'b1) : '0;
    row_n = state == DRAW ? (col == COL_W'(SPRITE_W - 1) ? row + 1'b1 : row) : '0;
  end
  always_ff @(posedge clk) begin
    state <= !resetn ? IDLE : nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (pick_valid ? LOAD : IDLE) :
          state == LOAD ? DRAW :
          state == DRAW ? (last ? DONE : DRAW) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
      grant <= '0;
      bx <= '0;
      by <= '0;
      fat <= '0;
      muscle <= '0;
      col <= '0;
      row <= '0;
    end else begin
      if (state == IDLE && pick_valid) grant <= pick_idx;
      if (state == LOAD) begin
        bx <= src_bx;
        by <= src_by;
        fat <= src_fat;
        muscle <= src_muscle;
      end
      if (state == DONE) ptr <= grant == IDX_W'(NUM_SLOTS - 1) ? '0 : grant + 1'b1;
      col <= col_n;
      row <= row_n;
    end
  end
  // outputs are registered from the next state so they line up with the DRAW/DONE cycles
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_out <= '0;
      y_out <= '0;
      colour_out <= '0;
      plot <= 1'b0;
      ack <= '0;
      busy <= 1'b0;
    end else begin
      plot <= nxt == DRAW;
      busy <= nxt != IDLE;
      ack <= nxt == DONE ? NUM_SLOTS'(1) << grant : '0;
      if (nxt == DRAW) begin
        x_out <= src_bx + COORD_W'(col_n);
        y_out <= src_by + COORD_W'(row_n);
        colour_out <= is_border(int'(col_n), int'(row_n), SPRITE_W, SPRITE_H) ? src_fat : src_muscle;
      end
    end
  end
endmodule
